// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM-loader handshake.
// Used by both the loader driver and the responder.
package rom_loader_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ROM_DEPTH  = 32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ACK
    } state_t;

endpackage

// File: rtl/rom_loader_responder.sv
// Receiving end of the ROM-loader handshake: captures words,
// writes them sequentially into the Hack ROM, holds the CPU.
module rom_loader_responder
    import rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROM_DEPTH  = DEF_ROM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(ROM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_loader_reset,
    input  logic                  rom_loader_load,
    input  logic [DATA_WIDTH-1:0] rom_loader_data,
    output logic                  rom_loader_load_received,
    output logic                  rom_loader_ack,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    input  logic                  rom_ready,
    output logic [ADDR_WIDTH:0]   loaded_words,
    output logic                  overflow,
    output logic                  cpu_hold
);

    // The address keeps one spare bit so it can reach ROM_DEPTH,
    // which marks every later word as dropped without wrapping.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_addr;
    logic [ADDR_WIDTH:0]   r_loaded_words;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_load_received;
    logic                  r_ack;
    logic                  r_rom_we;
    logic                  r_overflow;
    logic                  r_cpu_hold;
    logic                  r_drop;

    logic                  w_room;

    // A word fits while the next address is still inside the ROM.
    always_comb begin
        w_room = (r_addr < LP_DEPTH);
    end

    // Handshake FSM with registered outputs and address/count tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_loaded_words  <= '0;
            r_wdata         <= '0;
            r_load_received <= 1'b0;
            r_ack           <= 1'b0;
            r_rom_we        <= 1'b0;
            r_overflow      <= 1'b0;
            r_cpu_hold      <= 1'b0;
            r_drop          <= 1'b0;
        end else if (rom_loader_reset) begin
            // Restart aborts any write in flight; no ack follows.
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_loaded_words  <= '0;
            r_load_received <= 1'b0;
            r_ack           <= 1'b0;
            r_rom_we        <= 1'b0;
            r_overflow      <= 1'b0;
            r_cpu_hold      <= 1'b1;
            r_drop          <= 1'b0;
        end else begin
            r_load_received <= 1'b0;
            r_ack           <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rom_loader_load) begin
                        r_wdata         <= rom_loader_data;
                        r_load_received <= 1'b1;
                        if (w_room) begin
                            r_rom_we <= 1'b1;
                            r_drop   <= 1'b0;
                            r_state  <= ST_WRITE;
                        end else begin
                            // Dropped word: ack while in ACK, no write.
                            r_overflow <= 1'b1;
                            r_drop     <= 1'b1;
                            r_ack      <= 1'b1;
                            r_state    <= ST_ACK;
                        end
                    end else if (r_cpu_hold && (r_loaded_words != '0)) begin
                        r_cpu_hold <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (rom_ready) begin
                        r_rom_we <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    if (!r_drop) begin
                        r_addr         <= r_addr + LP_ONE;
                        r_loaded_words <= r_loaded_words + LP_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_loader_load_received = r_load_received;
    assign rom_loader_ack           = r_ack;
    assign rom_we                   = r_rom_we;
    assign rom_addr                 = r_addr[ADDR_WIDTH-1:0];
    assign rom_wdata                = r_wdata;
    assign loaded_words             = r_loaded_words;
    assign overflow                 = r_overflow;
    assign cpu_hold                 = r_cpu_hold;

endmodule

// File: tb/tb_rom_loader_responder.sv
// Bench for rom_loader_responder: a driver issues words, a
// monitor checks ROM writes and ack timing from a scoreboard.
module tb_rom_loader_responder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rom_loader_reset = 1'b0;
    logic          rom_loader_load = 1'b0;
    logic [DW-1:0] rom_loader_data = '0;
    logic          rom_ready = 1'b1;
    logic          load_received;
    logic          ack;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_wdata;
    logic [AW:0]   loaded_words;
    logic          overflow;
    logic          cpu_hold;

    rom_loader_responder #(
        .DATA_WIDTH(DW),
        .ROM_DEPTH (DEPTH)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rom_loader_reset        (rom_loader_reset),
        .rom_loader_load         (rom_loader_load),
        .rom_loader_data         (rom_loader_data),
        .rom_loader_load_received(load_received),
        .rom_loader_ack          (ack),
        .rom_we                  (rom_we),
        .rom_addr                (rom_addr),
        .rom_wdata               (rom_wdata),
        .rom_ready               (rom_ready),
        .loaded_words            (loaded_words),
        .overflow                (overflow),
        .cpu_hold                (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_wr[$];
    bit  exp_kind[$];
    bit  mon_en = 0;
    bit  ack_next = 0;
    bit  rdy_rand = 0;

    // Reference model of the loader session.
    int  m_words = 0;
    bit  m_ovf = 0;
    bit  m_hold = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random ROM back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) rom_ready = ($urandom_range(0, 2) != 0);
    end

    // Monitor: ROM writes against the queue, ack timing.
    always @(negedge clk) begin
        bit drop_ack;
        bit k;
        wr_t w;
        if (mon_en) begin
            drop_ack = 0;
            if (load_received === 1'b1) begin
                if (exp_kind.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL capture: unexpected load_received");
                end else begin
                    k = exp_kind.pop_front();
                    chk("we_at_capture", {31'd0, rom_we}, {31'd0, k});
                    drop_ack = !k;
                end
            end
            chk("ack_timing", {31'd0, ack}, {31'd0, ack_next | drop_ack});
            ack_next = 0;
            if (rom_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rom_write: unexpected write addr %0h", rom_addr);
                end else begin
                    w = exp_wr[0];
                    chk("wr_addr", {30'd0, rom_addr}, {30'd0, w.a});
                    chk("wr_data", {16'd0, rom_wdata}, {16'd0, w.d});
                    if (rom_ready) begin
                        void'(exp_wr.pop_front());
                        ack_next = 1;
                    end
                end
            end
            if (reset || rom_loader_reset) begin
                exp_wr.delete();
                exp_kind.delete();
                ack_next = 0;
            end
        end
    end

    task automatic wait_lr(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (load_received) begin
                ok = 1;
                return;
            end
            tick();
        end
        errors++;
        checks++;
        $display("FAIL lr_timeout: no load_received within 50 cycles");
    endtask

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (ack) begin
                ok = 1;
                return;
            end
            tick();
        end
        errors++;
        checks++;
        $display("FAIL ack_timeout: no ack within 50 cycles");
    endtask

    task automatic expect_word(input logic [DW-1:0] d, output bit wr);
        wr_t w;
        wr = (m_words < DEPTH);
        exp_kind.push_back(wr);
        if (wr) begin
            w.a = m_words[AW-1:0];
            w.d = d;
            exp_wr.push_back(w);
        end
    endtask

    task automatic finish_word(input bit wr);
        bit ok;
        wait_ack(ok);
        tick();
        if (wr) m_words++;
        else m_ovf = 1;
        chk("loaded_words", {29'd0, loaded_words}, m_words);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit wr;
        bit ok;
        expect_word(d, wr);
        rom_loader_load = 1;
        rom_loader_data = d;
        wait_lr(ok);
        rom_loader_load = 0;
        rom_loader_data = DW'($urandom);
        if (ok) finish_word(wr);
    endtask

    task automatic restart();
        rom_loader_reset = 1;
        tick();
        rom_loader_reset = 0;
        m_words = 0;
        m_ovf   = 0;
        m_hold  = 1;
        chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
        chk("restart_words", {29'd0, loaded_words}, 32'd0);
    endtask

    task automatic idle_check();
        rom_loader_load = 0;
        tick();
        if (m_words != 0) m_hold = 0;
        chk("cpu_hold_idle", {31'd0, cpu_hold}, {31'd0, m_hold});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_lr"}, {31'd0, load_received}, 32'd0);
        chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
        chk({tag, "_we"}, {31'd0, rom_we}, 32'd0);
        chk({tag, "_addr"}, {30'd0, rom_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, rom_wdata}, 32'd0);
        chk({tag, "_words"}, {29'd0, loaded_words}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    endtask

    initial begin
        bit ok;
        bit wr;
        int we_cnt;
        int lr_cnt;
        logic [DW-1:0] d;

        tick();
        tick();
        reset = 0;
        check_reset_values("por");
        mon_en = 1;

        // Three fixed words, ROM always ready.
        rdy_rand  = 0;
        rom_ready = 1;
        restart();
        send_word(16'h1234);
        send_word(16'hABCD);
        send_word(16'h0001);
        chk("three_words", {29'd0, loaded_words}, 32'd3);
        idle_check();

        // ROM stalls five cycles on the first word.
        restart();
        rom_ready = 0;
        expect_word(16'h5A5A, wr);
        rom_loader_load = 1;
        rom_loader_data = 16'h5A5A;
        wait_lr(ok);
        rom_loader_load = 0;
        we_cnt = 0;
        lr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rom_ready = 1;
            we_cnt += int'(rom_we);
            lr_cnt += int'(load_received);
            tick();
        end
        chk("stall_we_cycles", we_cnt, 32'd6);
        chk("stall_lr_once", lr_cnt, 32'd1);
        chk("stall_ack", {31'd0, ack}, 32'd1);
        chk("stall_we_drop", {31'd0, rom_we}, 32'd0);
        tick();
        m_words = 1;
        chk("stall_words", {29'd0, loaded_words}, 32'd1);

        // Fill past the ROM end with random back-pressure.
        rdy_rand = 1;
        restart();
        for (int i = 0; i < 6; i++) send_word(DW'($urandom));
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_words", {29'd0, loaded_words}, 32'd4);

        // Global reset while a dropped word is being handshaked.
        expect_word(16'hBEEF, wr);
        rom_loader_load = 1;
        rom_loader_data = 16'hBEEF;
        wait_lr(ok);
        rom_loader_load = 0;
        reset = 1;
        tick();
        reset = 0;
        m_words = 0;
        m_ovf   = 0;
        m_hold  = 0;
        check_reset_values("mid_reset");

        // Restart aborts a stalled write.
        restart();
        send_word(DW'($urandom));
        send_word(DW'($urandom));
        rdy_rand  = 0;
        rom_ready = 0;
        expect_word(16'hC0DE, wr);
        rom_loader_load = 1;
        rom_loader_data = 16'hC0DE;
        wait_lr(ok);
        rom_loader_load = 0;
        rom_loader_reset = 1;
        tick();
        rom_loader_reset = 0;
        m_words = 0;
        m_ovf   = 0;
        m_hold  = 1;
        chk("abort_we", {31'd0, rom_we}, 32'd0);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_addr", {30'd0, rom_addr}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
        tick();
        chk("abort_no_ack", {31'd0, ack}, 32'd0);
        rdy_rand = 1;
        send_word(16'h7777);

        // Restart and load in the same cycle.
        d = 16'h4321;
        rom_loader_load  = 1;
        rom_loader_data  = d;
        rom_loader_reset = 1;
        tick();
        rom_loader_reset = 0;
        m_words = 0;
        m_ovf   = 0;
        m_hold  = 1;
        chk("coinc_no_lr", {31'd0, load_received}, 32'd0);
        chk("coinc_no_we", {31'd0, rom_we}, 32'd0);
        expect_word(d, wr);
        tick();
        chk("coinc_lr_next", {31'd0, load_received}, 32'd1);
        rom_loader_load = 0;
        finish_word(wr);
        idle_check();

        // Random sessions.
        for (int s = 0; s < 4; s++) begin
            restart();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                send_word(DW'($urandom));
            idle_check();
        end

        rdy_rand = 0;
        tick();
        tick();
        if (exp_wr.size() != 0 || exp_kind.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d writes %0d captures outstanding",
                     exp_wr.size(), exp_kind.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
